// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer slice: FSM states, op codes
// and instruction field layout.
package alu_pkg;

    localparam int INSTR_W = 8;
    localparam int FLD_W   = 2;
    localparam int OP_LO   = 6;
    localparam int RI_LO   = 4;
    localparam int RJ_LO   = 2;
    localparam int RK_LO   = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } alu_op_e;

    function automatic logic [FLD_W-1:0] fld(
        input logic [INSTR_W-1:0] w,
        input int                 lo
    );
        return w[lo +: FLD_W];
    endfunction

endpackage

// File: rtl/alu_prog_mem.sv
// Program store: single write port, registered read port.
// The read register holds its value until the next enabled read.
module alu_prog_mem
    import alu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [INSTR_W-1:0] wr_data_i,
    input  logic               rd_en_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [INSTR_W-1:0] rd_data_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rd_data_q;

    // program array write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // read register, cleared by reset so downstream selects start at 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer driving the ALU register-file selects.
// Optional feature macro: ALU_SEQ_LOOP_EN (adds the loop input).
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              hold,
`ifdef ALU_SEQ_LOOP_EN
    input  logic              loop,
`endif
    output logic [1:0]        sel_Ri,
    output logic [1:0]        sel_Rj,
    output logic [1:0]        sel_Rk,
    output logic [1:0]        sel_op,
    output logic              issue,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(PROG_DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic [ADDR_W:0]    len_sat;
    logic               last_w;
    logic               wr_en;
    logic               rd_en;
    logic [INSTR_W-1:0] rd_data;
`ifdef ALU_SEQ_LOOP_EN
    logic               loop_q, loop_d;
`endif

    assign len_sat = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_w  = ({1'b0, pc_q} == (len_q - LEN_ONE));

    // state, pc and run-length registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
        end
    end

`ifdef ALU_SEQ_LOOP_EN
    // loop request sampled at start and at each wrap-around
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loop_q <= 1'b0;
        end else begin
            loop_q <= loop_d;
        end
    end
`endif

    // next-state, pc update and memory strobes
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
`ifdef ALU_SEQ_LOOP_EN
        loop_d  = loop_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                wr_en = load_en;
                if (start) begin
                    len_d = len_sat;
                    pc_d  = '0;
`ifdef ALU_SEQ_LOOP_EN
                    loop_d = loop;
`endif
                    if (len_sat != '0) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (!hold) begin
                    rd_en   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!hold) begin
                    if (last_w) begin
`ifdef ALU_SEQ_LOOP_EN
                        if (loop_q && loop) begin
                            pc_d    = '0;
                            loop_d  = loop;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_DONE;
                        end
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    alu_prog_mem #(
        .DEPTH  (PROG_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i     (clk),
        .rst_ni    (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (load_addr),
        .wr_data_i (load_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (pc_q),
        .rd_data_o (rd_data)
    );

    assign sel_op = fld(rd_data, OP_LO);
    assign sel_Ri = fld(rd_data, RI_LO);
    assign sel_Rj = fld(rd_data, RJ_LO);
    assign sel_Rk = fld(rd_data, RK_LO);
    assign issue  = (state_q == S_ISSUE) && !hold;
    assign busy   = (state_q == S_FETCH) || (state_q == S_ISSUE);
    assign done   = (state_q == S_DONE);
    assign pc     = pc_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl.
// Loop scenario is compiled in with ALU_SEQ_LOOP_EN.
module tb_alu_seq_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          load_en   = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [7:0]    load_data = '0;
    logic [AW:0]   prog_len  = '0;
    logic          start     = 1'b0;
    logic          hold      = 1'b0;
`ifdef ALU_SEQ_LOOP_EN
    logic          loop      = 1'b0;
`endif
    logic [1:0]    sel_Ri, sel_Rj, sel_Rk, sel_op;
    logic          issue, busy, done;
    logic [AW-1:0] pc;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [7:0]  mem_m [DEPTH];
    logic [31:0] exp_q [$];
    int          issue_log [$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          busy_cnt = 0;
    int          t0;

    alu_seq_ctrl #(.PROG_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .prog_len  (prog_len),
        .start     (start),
        .hold      (hold),
`ifdef ALU_SEQ_LOOP_EN
        .loop      (loop),
`endif
        .sel_Ri    (sel_Ri),
        .sel_Rj    (sel_Rj),
        .sel_Rk    (sel_Rk),
        .sel_op    (sel_op),
        .issue     (issue),
        .pc        (pc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {17'h0, sel_op, sel_Ri, sel_Rj, sel_Rk, pc,
                issue, busy, done};
    endfunction

    function automatic logic [31:0] issued_word();
        return {16'h0, sel_op, sel_Ri, sel_Rj, sel_Rk, 4'h0, pc};
    endfunction

    function automatic int log_at(input int k);
        return (issue_log.size() > k) ? issue_log[k] : -1;
    endfunction

    // monitor: pop scoreboard on every issue, log done/busy
    always @(negedge clk) begin
        if (reset) begin
            if (issue) begin
                issue_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 32'(exp_q.size()), 1);
                end else begin
                    check("issue_sel", issued_word(), exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [7:0] d);
        load_addr = AW'(a);
        load_data = d;
        load_en   = 1'b1;
        tick();
        load_en   = 1'b0;
        mem_m[a]  = d;
    endtask

    task automatic push_pass(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({16'h0, mem_m[i], 4'h0, 4'(i)});
        end
    endtask

    task automatic start_run(input int len, output int t);
        push_pass(len > DEPTH ? DEPTH : len);
        issue_log.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        busy_cnt  = 0;
        prog_len  = (AW+1)'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        t         = cyc - 1;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && done_cnt == 0; i++) tick();
        check("done_seen", 32'(done_cnt), 1);
    endtask

    initial begin
        #2;
        check("reset_outs", outs(), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("idle_busy", {31'h0, busy}, 0);

        load_word(0, 8'h1B);
        load_word(1, 8'h64);
        load_word(2, 8'hE2);

        // three-instruction run
        start_run(3, t0);
        wait_done(40);
        check("run3_n", 32'(issue_log.size()), 3);
        check("run3_i0", 32'(log_at(0)), 32'(t0 + 2));
        check("run3_i1", 32'(log_at(1)), 32'(t0 + 4));
        check("run3_i2", 32'(log_at(2)), 32'(t0 + 6));
        check("run3_done", 32'(done_cyc), 32'(t0 + 7));
        check("run3_sb", 32'(exp_q.size()), 0);

        // zero-length run
        start_run(0, t0);
        wait_done(10);
        check("zero_done", 32'(done_cyc), 32'(t0 + 1));
        check("zero_issue", 32'(issue_log.size()), 0);
        check("zero_busy", 32'(busy_cnt), 0);

        // hold across the issue of instruction 1
        start_run(3, t0);
        tick();
        tick();
        tick();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_issue", {31'h0, issue}, 0);
            check("hold_sel", {24'h0, sel_op, sel_Ri, sel_Rj, sel_Rk},
                  32'h64);
            tick();
        end
        hold = 1'b0;
        wait_done(40);
        check("hold_i1", 32'(log_at(1)), 32'(t0 + 7));
        check("hold_i2", 32'(log_at(2)), 32'(t0 + 9));
        check("hold_done", 32'(done_cyc), 32'(t0 + 10));

        // start and load while busy are ignored
        start_run(3, t0);
        tick();
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = '0;
        load_data = 8'hFF;
        prog_len  = 5'd1;
        tick();
        start     = 1'b0;
        load_en   = 1'b0;
        wait_done(40);
        check("ign_done", 32'(done_cyc), 32'(t0 + 7));
        check("ign_n", 32'(issue_log.size()), 3);
        tick();
        tick();
        check("ign_norestart", {31'h0, busy}, 0);
        start_run(1, t0);
        wait_done(10);
        check("ign_word0_n", 32'(issue_log.size()), 1);

        // prog_len above depth saturates
        for (int i = 0; i < DEPTH; i++) load_word(i, 8'($urandom));
        start_run(20, t0);
        wait_done(80);
        check("sat_n", 32'(issue_log.size()), DEPTH);
        check("sat_done", 32'(done_cyc), 32'(t0 + 2 * DEPTH + 1));
        check("sat_sb", 32'(exp_q.size()), 0);

        // asynchronous reset mid-run
        start_run(3, t0);
        tick();
        check("pre_rst_issue", {31'h0, issue}, 1);
        reset = 1'b0;
        #1;
        check("rst_outs", outs(), 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_idle", {31'h0, busy}, 0);
        start_run(2, t0);
        wait_done(20);
        check("rst_rerun_done", 32'(done_cyc), 32'(t0 + 5));

`ifdef ALU_SEQ_LOOP_EN
        // looping run, loop dropped during the third pass
        loop = 1'b1;
        start_run(2, t0);
        push_pass(2);
        push_pass(2);
        for (int i = 0; i < 9; i++) tick();
        loop = 1'b0;
        wait_done(40);
        check("loop_n", 32'(issue_log.size()), 6);
        check("loop_done", 32'(done_cyc), 32'(t0 + 13));
        check("loop_sb", 32'(exp_q.size()), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
